// File: rtl/qam_iq_mod_mul.sv
// Square-QAM I/Q mixer: holds one symbol for SPS carrier samples and emits sat(I*cos - Q*sin).
// Optional QAM_GRAY_MAP_EN: Gray-decode each axis index before the level lookup.
module qam_iq_mod_mul #(
  parameter int DATA_W        = 8,
  parameter int COEF_W        = 8,
  parameter int BITS_PER_AXIS = 2,
  parameter int SPS           = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  input  logic [BITS_PER_AXIS-1:0] sym_i,
  input  logic [BITS_PER_AXIS-1:0] sym_q,
  input  logic                     car_valid,
  input  logic signed [DATA_W-1:0] car_cos,
  input  logic signed [DATA_W-1:0] car_sin,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid,
  output logic                     underrun,
  output logic                     busy
);

  localparam int B     = BITS_PER_AXIS;
  localparam int L     = 1 << B;
  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int PW    = DATA_W + COEF_W;
  localparam logic signed [PW-1:0] SMAX = PW'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN = -SMAX - PW'(1);

  typedef logic signed [COEF_W-1:0] coef_t;

  // Symmetric level (2k-(L-1))/(2(L-1)) in COEF_W fixed point, rounded half away from zero.
  function automatic coef_t calcCoef(input int k);
    longint num, den, mag, q;
    num = longint'(2 * k - (L - 1)) * (longint'(1) << (COEF_W - 1));
    den = longint'(2 * (L - 1));
    mag = (num < 0) ? -num : num;
    q   = (2 * mag + den) / (2 * den);
    return coef_t'((num < 0) ? -q : q);
  endfunction

  function automatic logic [B-1:0] toLevel(input logic [B-1:0] idx);
`ifdef QAM_GRAY_MAP_EN
    logic [B-1:0] k;
    k[B-1] = idx[B-1];
    for (int b = B - 2; b >= 0; b--) k[b] = k[b+1] ^ idx[b];
    return k;
`else
    return idx;
`endif
  endfunction

  coef_t coefTab [L];
  for (genvar g = 0; g < L; g++) begin : g_tab
    assign coefTab[g] = calcCoef(g);
  end

  logic             loaded_q, loaded_d;
  logic [B-1:0]     symI_q, symI_d, symQ_q, symQ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             v1_q, und1_q, v2_q, und2_q;
  coef_t            coefI1_q, coefQ1_q;
  logic signed [DATA_W-1:0] cos1_q, sin1_q, out_q;

  logic  cntLast, accept;
  coef_t coefI, coefQ;

  assign cntLast   = (cnt_q == CNT_W'(SPS - 1));
  assign sym_ready = rst_n & (!loaded_q | (car_valid & cntLast));
  assign accept    = sym_valid & sym_ready;
  assign coefI     = loaded_q ? coefTab[toLevel(symI_q)] : '0;
  assign coefQ     = loaded_q ? coefTab[toLevel(symQ_q)] : '0;

  // A boundary accept overrides the wrap-clear so the next symbol follows with no gap.
  always_comb begin
    loaded_d = loaded_q;
    symI_d   = symI_q;
    symQ_d   = symQ_q;
    cnt_d    = cnt_q;
    if (car_valid && loaded_q) begin
      if (cntLast) begin
        cnt_d    = '0;
        loaded_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (accept) begin
      loaded_d = 1'b1;
      cnt_d    = '0;
      symI_d   = sym_i;
      symQ_d   = sym_q;
    end
  end

  logic signed [PW-1:0]     prodI, prodQ, sumWide;
  logic signed [DATA_W-1:0] satSum;

  assign prodI   = cos1_q * coefI1_q;
  assign prodQ   = sin1_q * coefQ1_q;
  assign sumWide = (prodI >>> (COEF_W - 1)) - (prodQ >>> (COEF_W - 1));

  always_comb begin
    satSum = sumWide[DATA_W-1:0];
    if (sumWide > SMAX)      satSum = SMAX[DATA_W-1:0];
    else if (sumWide < SMIN) satSum = SMIN[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaded_q <= 1'b0;
      symI_q   <= '0;
      symQ_q   <= '0;
      cnt_q    <= '0;
      v1_q     <= 1'b0;
      und1_q   <= 1'b0;
      coefI1_q <= '0;
      coefQ1_q <= '0;
      cos1_q   <= '0;
      sin1_q   <= '0;
      v2_q     <= 1'b0;
      und2_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      loaded_q <= loaded_d;
      symI_q   <= symI_d;
      symQ_q   <= symQ_d;
      cnt_q    <= cnt_d;
      v1_q     <= car_valid;
      und1_q   <= car_valid & !loaded_q;
      if (car_valid) begin
        coefI1_q <= coefI;
        coefQ1_q <= coefQ;
        cos1_q   <= car_cos;
        sin1_q   <= car_sin;
      end
      v2_q   <= v1_q;
      und2_q <= v1_q & und1_q;
      if (v1_q) out_q <= satSum;
    end
  end

  assign out       = out_q;
  assign out_valid = v2_q;
  assign underrun  = und2_q;
  assign busy      = loaded_q | v1_q | v2_q;

endmodule

// File: tb/tb_qam_iq_mod_mul.sv
// Scoreboard bench for qam_iq_mod_mul with directed vectors; honours QAM_GRAY_MAP_EN.
module tb_qam_iq_mod_mul;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sym_valid, car_valid;
  logic              sym_ready, out_valid, underrun, busy;
  logic [1:0]        sym_i, sym_q;
  logic signed [7:0] car_cos, car_sin, outS;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic signed [7:0] o;
    logic              u;
    int                c;
  } exp_t;
  exp_t expQ[$];

  // Index that selects level k (0..3) under the active mapping.
`ifdef QAM_GRAY_MAP_EN
  localparam logic [1:0] IX0 = 2'd0, IX1 = 2'd1, IX2 = 2'd3, IX3 = 2'd2;
  localparam int RAW2_OUT = 50;
`else
  localparam logic [1:0] IX0 = 2'd0, IX1 = 2'd1, IX2 = 2'd2, IX3 = 2'd3;
  localparam int RAW2_OUT = 16;
`endif

  qam_iq_mod_mul #(.DATA_W(8), .COEF_W(8), .BITS_PER_AXIS(2), .SPS(4)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_i(sym_i), .sym_q(sym_q), .car_valid(car_valid), .car_cos(car_cos),
    .car_sin(car_sin), .out(outS), .out_valid(out_valid), .underrun(underrun),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_out actual=%0d expected=none", outS);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("out", int'(outS), int'(e.o));
        checkOutput("underrun", int'(underrun), int'(e.u));
        checkOutput("latency_cycle", cyc, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sv, input logic [1:0] si, input logic [1:0] sq,
                               input logic cv, input logic signed [7:0] cs,
                               input logic signed [7:0] sn, input logic push,
                               input logic signed [7:0] eo, input logic eu,
                               input logic expReady);
    sym_valid = sv;
    sym_i     = si;
    sym_q     = sq;
    car_valid = cv;
    car_cos   = cs;
    car_sin   = sn;
    #1;
    if (sv) checkOutput("sym_ready", int'(sym_ready), int'(expReady));
    if (push) expQ.push_back('{eo, eu, cyc + 2});
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 1'b0, 1'b0);
  endtask

  task automatic strobes(input int n, input logic signed [7:0] cs, input logic signed [7:0] sn,
                         input logic signed [7:0] eo);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, cs, sn, 1'b1, eo, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    sym_valid = 1'b0; car_valid = 1'b0;
    sym_i = '0; sym_q = '0; car_cos = '0; car_sin = '0;
    #1;
    // Reset with random inputs
    for (int k = 0; k < 3; k++) begin
      sym_valid = 1'($urandom); car_valid = 1'($urandom);
      sym_i = 2'($urandom); sym_q = 2'($urandom);
      car_cos = 8'($urandom); car_sin = 8'($urandom);
      step();
      checkOutput("rst_out", int'(outS), 0);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_underrun", int'(underrun), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_sym_ready", int'(sym_ready), 0);
    end
    sym_valid = 1'b0; car_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_sym_ready", int'(sym_ready), 1);
    step();

    // Single axis full-scale, then an underrun strobe
    applyStimulus(1'b1, IX3, IX0, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 1'b0, 1'b1);
    strobes(4, 8'sd100, 8'sd0, 8'sd50);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'sd100, 8'sd0, 1'b1, 8'sd0, 1'b1, 1'b0);
    idle(4);
    checkOutput("idle_busy", int'(busy), 0);

    // Both axes, mixed signs: 16 - 8
    applyStimulus(1'b1, IX1, IX2, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 1'b0, 1'b1);
    strobes(4, -8'sd100, 8'sd50, 8'sd8);
    idle(3);

    // Saturation both directions
    applyStimulus(1'b1, IX0, IX0, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 1'b0, 1'b1);
    strobes(2, -8'sd128, 8'sd127, 8'sd127);
    strobes(2, 8'sd127, -8'sd128, -8'sd128);
    idle(3);

    // Back-to-back symbols accepted on the boundary strobe
    applyStimulus(1'b1, IX3, IX0, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 1'b0, 1'b1);
    strobes(3, 8'sd100, 8'sd0, 8'sd50);
    applyStimulus(1'b1, IX1, IX0, 1'b1, 8'sd100, 8'sd0, 1'b1, 8'sd50, 1'b0, 1'b1);
    strobes(4, 8'sd100, 8'sd0, -8'sd17);
    idle(3);
    checkOutput("b2b_busy", int'(busy), 0);

    // Reset mid-symbol: second strobe's output is flushed
    applyStimulus(1'b1, IX3, IX0, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 1'b0, 1'b1);
    strobes(1, 8'sd100, 8'sd0, 8'sd50);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'sd100, 8'sd0, 1'b0, 8'sd0, 1'b0, 1'b0);
    car_valid = 1'b0;
    rst_n = 1'b0;
    step();
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(4);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 8'sd100, 8'sd0, 1'b1, 8'sd0, 1'b1, 1'b0);
    idle(3);

    // Raw index 2 exposes the index-to-level mapping
    applyStimulus(1'b1, 2'd2, 2'd0, 1'b0, 8'sd0, 8'sd0, 1'b0, 8'sd0, 1'b0, 1'b1);
    strobes(4, 8'sd100, 8'sd0, 8'(RAW2_OUT));
    idle(4);

    checkOutput("pending_expectations", expQ.size(), 0);
    checkOutput("final_busy", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
